// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package mult_pkg;
   localparam int MULT_W = 8;
   localparam int CNT_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;
endpackage : mult_pkg

// File: rtl/ripple8.sv
// 8-bit ripple-carry adder: sum/co = a + b + cin.
module ripple8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       co
);
   logic [8:0] c;

   assign c[0] = cin;

   // One full adder per bit; the carry ripples from bit 0 upwards.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_fa
         assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign co = c[8];
endmodule : ripple8

// File: rtl/shift_add_mult8.sv
// Sequential 8x8 unsigned multiplier: one add-and-shift step per cycle for
// 8 cycles, using a single ripple8 as the only adder. Valid/ready on both sides.
module shift_add_mult8
   import mult_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [MULT_W-1:0]   a,
   input  logic [MULT_W-1:0]   b,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [2*MULT_W-1:0] p,
   output logic                busy
);
   state_t              state;
   logic [MULT_W-1:0]   mcand;
   logic [2*MULT_W-1:0] prod;
   logic [CNT_W-1:0]    cnt;

   logic [MULT_W-1:0]   addend;
   logic [MULT_W-1:0]   sum;
   logic                co;

   // Add the multiplicand into the high half only when the current multiplier bit is set.
   assign addend = prod[0] ? mcand : '0;

   ripple8 u_add (
      .a   (prod[2*MULT_W-1:MULT_W]),
      .b   (addend),
      .cin (1'b0),
      .sum (sum),
      .co  (co)
   );

   // The product register is only observed while out_valid is high, so it
   // drives p directly; it is held untouched throughout DONE.
   assign p = prod;

   // Control FSM, step counter and product shift register, with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mcand     <= '0;
         prod      <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid && in_ready) begin
                  mcand    <= a;
                  prod     <= {{MULT_W{1'b0}}, b};
                  cnt      <= '0;
                  state    <= ST_CALC;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            ST_CALC: begin
               // Carry out lands in bit 15 as the whole register shifts right.
               prod <= {co, sum, prod[MULT_W-1:1]};
               cnt  <= cnt + 3'd1;
               if (cnt == 3'd7) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_valid && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end
endmodule : shift_add_mult8

// File: tb/tb_shift_add_mult8.sv
// Self-checking bench for shift_add_mult8: directed operand pairs with
// literal products, a cycle-level reference model, and a random stream.
module tb_shift_add_mult8;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   shift_add_mult8 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted pair yields a*b after 8 cycles, held until taken.
   bit          m_idle = 1'b1;
   bit          m_valid = 1'b0;
   int          m_left = 0;
   logic [15:0] m_p = '0;
   longint      cyc = 0;
   longint      last_acc = 0;
   bit          have_last = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle    = 1'b1;
         m_valid   = 1'b0;
         m_left    = 0;
         have_last = 1'b0;
      end else begin
         cyc++;
         if (m_idle) begin
            if (in_valid) begin
               m_p    = 16'(a) * 16'(b);
               m_left = 8;
               m_idle = 1'b0;
               if (have_last)
                  chk("issue_interval_ge10", 32'(cyc - last_acc >= 10), 32'd1);
               last_acc  = cyc;
               have_last = 1'b1;
            end
         end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
         end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
         end
      end
   end

   // Every cycle out of reset, the DUT outputs must match the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("model_in_ready", 32'(in_ready), 32'(m_idle));
         chk("model_busy", 32'(busy), 32'(!m_idle));
         chk("model_out_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) chk("model_p", 32'(p), 32'(m_p));
      end
   end

   // One operation: issue a/b, optionally check latency, stall the consumer, then take p.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_b, input logic [15:0] exp,
                        input int stall, input bit chk_lat, input bit inject, input bit rnd_rdy);
      int n;
      n = 0;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("wait_in_ready", 32'(in_ready), 32'd1);
      a = ta;
      b = tb_b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      n = 0;
      while (!out_valid && n < 50) begin
         out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         n++;
      end
      chk("wait_out_valid", 32'(out_valid), 32'd1);
      if (chk_lat) chk("latency", 32'(n), 32'd8);
      out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
         if (inject) begin
            in_valid = 1'b1;
            a = 8'd1;
            b = 8'd1;
         end
         @(negedge clk);
         chk("stall_p_hold", 32'(p), 32'(exp));
         chk("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      chk("result_p", 32'(p), 32'(exp));
      $display("op a=%0d b=%0d p=%04h expected=%04h stall=%0d", ta, tb_b, p, exp, stall);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("after_handshake_out_valid", 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [7:0] ra, rb;
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      repeat (3) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_p", 32'(p), 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      do_op(8'hFF, 8'hFF, 16'hFE01, 0, 1'b1, 1'b0, 1'b0);
      do_op(8'd13, 8'd11, 16'h008F, 0, 1'b1, 1'b0, 1'b0);
      do_op(8'h80, 8'h02, 16'h0100, 0, 1'b0, 1'b0, 1'b0);
      do_op(8'h00, 8'hA5, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
      do_op(8'h5A, 8'h00, 16'h0000, 0, 1'b0, 1'b0, 1'b0);
      do_op(8'd7, 8'd9, 16'h003F, 5, 1'b0, 1'b1, 1'b0);

      // Reset in the middle of CALC discards the operation.
      a = 8'd200;
      b = 8'd200;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      chk("midcalc_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_in_ready", 32'(in_ready), 32'd1);
      chk("async_reset_out_valid", 32'(out_valid), 32'd0);
      chk("async_reset_busy", 32'(busy), 32'd0);
      chk("async_reset_p", 32'(p), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      do_op(8'd3, 8'd5, 16'h000F, 0, 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < 20; k++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         do_op(ra, rb, 16'(ra) * 16'(rb), int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule : tb_shift_add_mult8

// File: doc/shift_add_mult8.md
# shift_add_mult8

Sequential 8x8 unsigned multiplier that computes a 16-bit product by shift-and-add over 8 cycles. It reuses one `ripple8` instance as its only adder. It sits directly downstream of the 8-bit ripple-carry adder, consuming its sum and carry every cycle. It gives the datapath a multiply operation without a combinational array multiplier. Operands arrive and results leave over valid/ready handshakes.

## Interface
Parameters:
- None. Width is fixed at 8 to match `ripple8`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair present on `a`/`b`.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `a`  in  8  multiplicand, unsigned.
- `b`  in  8  multiplier, unsigned.
- `out_valid`  out  1  product on `p` is valid.
- `out_ready`  in  1  consumer accepts `p`.
- `p`  out  16  product a*b, registered.
- `busy`  out  1  high in CALC or DONE.

## Operation
- Registers:
  - `mcand[7:0]`: latched `a`.
  - `prod[15:0]`: hi = `prod[15:8]`, lo = `prod[7:0]`.
  - `cnt[2:0]`.
  - `state` ∈ {IDLE, CALC, DONE}.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `mcand`<=`a`, `prod`<={8'h00, `b`}, `cnt`<=0, go to CALC.
- CALC, once per cycle:
  - Adder inputs: hi, addend = `prod[0]` ? `mcand` : 8'h00, cin=0.
  - Adder output: {co, sum}.
  - Update: `prod`<={co, sum, `prod[7:1]`}.
  - `cnt`<=`cnt`+1.
  - When `cnt`==7, go to DONE (`cnt` wraps to 0).
- DONE:
  - `out_valid`=1 and `p`=`prod`.
  - Both hold stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- Arithmetic:
  - All values are unsigned.
  - The adder carry out becomes bit 15 after each shift.
  - The final value is exact: the maximum is 255*255 = 0xFE01, so there is no overflow.
- `in_valid` in CALC or DONE is ignored. Operands are not buffered, and `a`/`b` are not sampled.
- `out_ready` outside DONE is ignored.
- Reset, asynchronous at any time including mid-CALC:
  - `state`=IDLE; `prod`, `mcand`, `cnt` = 0.
  - The in-flight operation is discarded and no result is emitted.

## Timing
- Reset values:
  - `in_ready`=1.
  - `out_valid`=0, `busy`=0.
  - `p`=16'h0000.
- All outputs are decoded from registered state; there are no combinational input-to-output paths.
- Latency:
  - Accept edge E0.
  - CALC occupies edges E1..E8.
  - `out_valid` rises after E8, i.e. 8 cycles after acceptance.
- Minimum issue interval is 10 cycles:
  - Accept at E0.
  - With `out_ready` held high, output handshake at E9.
  - IDLE at E9; next accept at E10.
- Backpressure: DONE holds indefinitely. `p` must not change while `out_valid`=1 and `out_ready`=0.
- The adder path (8-bit ripple plus mux) must close within one clock period.

## Structure
- Shared package `mult_pkg`, holding:
  - `MULT_W`=8.
  - `CNT_W`=3.
  - State encodings `ST_IDLE`=2'd0, `ST_CALC`=2'd1, `ST_DONE`=2'd2.
- One sub-module: the existing `ripple8`, instantiated once as `u_add`.
  - Connected to hi, addend and cin=1'b0.
- The FSM, counter and shift register live in `shift_add_mult8` itself.

## Test plan
- Full carry:
  - `a`=8'hFF, `b`=8'hFF, `out_ready`=1 → `p`=16'hFE01.
  - `out_valid` rises exactly 8 cycles after accept.
- Plain case:
  - `a`=8'd13, `b`=8'd11 → `p`=16'h008F.
  - Follow-up `a`=8'h80, `b`=8'h02 → `p`=16'h0100.
- Zero operand:
  - `a`=8'h00, `b`=8'hA5 → `p`=16'h0000.
  - `b`=8'h00, `a`=8'h5A → `p`=16'h0000.
- Backpressure:
  - `a`=8'd7, `b`=8'd9, `out_ready` low for 5 cycles after `out_valid`.
  - `p`=16'h003F held stable throughout.
  - `in_ready`=0 until the handshake.
  - A new `in_valid` with `a`=8'd1, `b`=8'd1 during that window is ignored.
- Reset mid-operation:
  - Deassert `rst_n` at CALC cycle 4.
  - Outputs go immediately to reset values.
  - After release, `a`=8'd3, `b`=8'd5 → `p`=16'h000F.
- Back-to-back:
  - Stream 20 random pairs with random `out_ready`.
  - Every `p` equals a*b, in order.
  - Issue interval is never below 10 cycles.
